// File: rtl/cond_flag_unit.sv
// Condition/flag unit: stores ALU flags, evaluates ARM condition codes, issues gated strobes.
// Latency 1 cycle from accept to strobes/flags; stall=1 freezes every register (no internal buffering).
module cond_flag_unit #(
    parameter int                FLAG_W      = 4,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [1:0]        flag_w,
    input  logic              pcs_in,
    input  logic              reg_w_in,
    input  logic              mem_w_in,
    input  logic              no_write,
    output logic [FLAG_W-1:0] flags,
    output logic              cond_ex,
    output logic              pc_src,
    output logic              reg_write,
    output logic              mem_write,
    output logic              out_valid,
    output logic              undef_seen
);

    logic [FLAG_W-1:0] r_flags;
    logic              r_cond_ex;
    logic              r_pc_src;
    logic              r_reg_write;
    logic              r_mem_write;
    logic              r_out_valid;
    logic              r_undef_seen;

    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic              w_pass;
    logic              w_accept;
    logic              w_undef;
    logic [FLAG_W-1:0] w_flags_nxt;

    assign w_n      = r_flags[3];
    assign w_z      = r_flags[2];
    assign w_c      = r_flags[1];
    assign w_v      = r_flags[0];
    assign w_accept = in_valid & ~stall;
    assign w_undef  = (cond == 4'b1111);

    // Evaluated against the stored flags, i.e. before this instruction's own update.
    always_comb begin
        w_pass = 1'b0;
        case (cond)
            4'd0:    w_pass = w_z;
            4'd1:    w_pass = ~w_z;
            4'd2:    w_pass = w_c;
            4'd3:    w_pass = ~w_c;
            4'd4:    w_pass = w_n;
            4'd5:    w_pass = ~w_n;
            4'd6:    w_pass = w_v;
            4'd7:    w_pass = ~w_v;
            4'd8:    w_pass = w_c & ~w_z;
            4'd9:    w_pass = ~w_c | w_z;
            4'd10:   w_pass = (w_n == w_v);
            4'd11:   w_pass = (w_n != w_v);
            4'd12:   w_pass = ~w_z & (w_n == w_v);
            4'd13:   w_pass = w_z | (w_n != w_v);
            4'd14:   w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_flags_nxt = r_flags;
        if (w_pass) begin
            if (flag_w[1]) w_flags_nxt[3:2] = alu_flags[3:2];
            if (flag_w[0]) w_flags_nxt[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags      <= RESET_FLAGS;
            r_cond_ex    <= 1'b0;
            r_pc_src     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_undef_seen <= 1'b0;
        end else if (!stall) begin
            if (w_accept) begin
                r_flags     <= w_flags_nxt;
                r_cond_ex   <= w_pass;
                r_pc_src    <= pcs_in & w_pass;
                r_reg_write <= reg_w_in & ~no_write & w_pass;
                r_mem_write <= mem_w_in & w_pass;
                r_out_valid <= 1'b1;
                if (w_undef) r_undef_seen <= 1'b1;
            end else begin
                r_cond_ex   <= 1'b0;
                r_pc_src    <= 1'b0;
                r_reg_write <= 1'b0;
                r_mem_write <= 1'b0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign flags      = r_flags;
    assign cond_ex    = r_cond_ex;
    assign pc_src     = r_pc_src;
    assign reg_write  = r_reg_write;
    assign mem_write  = r_mem_write;
    assign out_valid  = r_out_valid;
    assign undef_seen = r_undef_seen;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit with hand-computed expected values.
module tb_cond_flag_unit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs_in;
    logic       reg_w_in;
    logic       mem_w_in;
    logic       no_write;
    logic [3:0] flags;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       out_valid;
    logic       undef_seen;

    int n_chk  = 0;
    int n_pass = 0;

    cond_flag_unit #(.FLAG_W(4), .RESET_FLAGS(4'b0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .stall      (stall),
        .cond       (cond),
        .alu_flags  (alu_flags),
        .flag_w     (flag_w),
        .pcs_in     (pcs_in),
        .reg_w_in   (reg_w_in),
        .mem_w_in   (mem_w_in),
        .no_write   (no_write),
        .flags      (flags),
        .cond_ex    (cond_ex),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .out_valid  (out_valid),
        .undef_seen (undef_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // strobe vector {cond_ex, pc_src, reg_write, mem_write, out_valid}
    function automatic logic [4:0] strobes();
        return {cond_ex, pc_src, reg_write, mem_write, out_valid};
    endfunction

    task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic pcs, input logic rw, input logic mw, input logic nw);
        @(negedge clk);
        in_valid  = 1'b1;
        cond      = c;
        flag_w    = fw;
        alu_flags = af;
        pcs_in    = pcs;
        reg_w_in  = rw;
        mem_w_in  = mw;
        no_write  = nw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; cond = 4'd0; alu_flags = 4'd0;
        flag_w = 2'b00; pcs_in = 1'b0; reg_w_in = 1'b0; mem_w_in = 1'b0; no_write = 1'b0;
        #2;
        chk("por_flags", flags, 4'b0000);
        chk("por_strobes", strobes(), 5'b00000);
        chk("por_undef", undef_seen, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // load 1111, then async reset mid-cycle must clear everything immediately
        issue(4'd14, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_flags", flags, 4'b1111);
        chk("pre_rst_strobes", strobes(), 5'b11111);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags", flags, 4'b0000);
        chk("async_rst_strobes", strobes(), 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        idle();
        chk("post_rst_idle", strobes(), 5'b00000);

        // AL with flag write, then EQ on the freshly written Z
        issue(4'd14, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("al_strobes", strobes(), 5'b10101);
        chk("al_flags", flags, 4'b0100);
        issue(4'd0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("eq_strobes", strobes(), 5'b10011);

        // NE fails: no pc_src and no flag update
        issue(4'd1, 2'b11, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ne_strobes", strobes(), 5'b00001);
        chk("ne_flags", flags, 4'b0100);
        idle();
        chk("idle_strobes", strobes(), 5'b00000);
        chk("idle_flags", flags, 4'b0100);

        // partial flag writes
        issue(4'd14, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_flags", flags, 4'b0000);
        issue(4'd14, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nz_only_flags", flags, 4'b1100);
        issue(4'd11, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lt_pass", cond_ex, 1'b1);
        issue(4'd10, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ge_fail", cond_ex, 1'b0);
        chk("ge_fail_flags", flags, 4'b1100);

        // no_write suppresses reg_write; HI/LS against C=1,Z=1
        issue(4'd14, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("nowr_strobes", strobes(), 5'b10001);
        chk("nowr_flags", flags, 4'b0110);
        issue(4'd8, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hi_fail", cond_ex, 1'b0);
        issue(4'd9, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ls_pass", strobes(), 5'b11001);

        // stall holds strobes and blocks cond=15
        @(negedge clk);
        stall = 1'b1;
        in_valid = 1'b1; cond = 4'd15; flag_w = 2'b11; alu_flags = 4'b1001; pcs_in = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_strobes", strobes(), 5'b11001);
        chk("stall_undef", undef_seen, 1'b0);
        chk("stall_flags", flags, 4'b0110);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("nv_undef", undef_seen, 1'b1);
        chk("nv_strobes", strobes(), 5'b00001);
        chk("nv_flags", flags, 4'b0110);

        for (int i = 0; i < 5; i++) begin
            issue(4'd14, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("undef_sticky_%0d", i), {undef_seen, cond_ex}, 2'b11);
        end
        idle();
        chk("final_idle", strobes(), 5'b00000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("undef_rst", undef_seen, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface. Captures the ALU's {Neg, Z, C, V} flags into an architectural flags register under per-group write enables.
- Evaluates each instruction's 4-bit ARM-style condition field against the stored flags, then issues gated, registered write-enable and PC-select strobes to the datapath.
- Sits between the decoder and the register file / data memory / PC mux.

Parameters:
- FLAG_W, 4, flag vector width, ordered {N, Z, C, V}. Fixed at 4; the parameter exists for documentation only.
- RESET_FLAGS, 4'b0000, flags register value after reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction is present this cycle
- stall  in  1  hold all state and registered outputs
- cond  in  4  instruction condition field
- alu_flags  in  4  {N, Z, C, V} from ALU for this instruction
- flag_w  in  2  [1] writes N,Z; [0] writes C,V
- pcs_in  in  1  instruction writes PC
- reg_w_in  in  1  instruction writes register file
- mem_w_in  in  1  instruction writes memory
- no_write  in  1  compare-type instruction; suppresses register write
- flags  out  4  current stored flags
- cond_ex  out  1  registered: last accepted instruction's condition passed
- pc_src  out  1  registered gated pcs_in
- reg_write  out  1  registered gated reg_w_in & ~no_write
- mem_write  out  1  registered gated mem_w_in
- out_valid  out  1  registered in_valid
- undef_seen  out  1  sticky: a cond=4'b1111 instruction was accepted

Behaviour:
- Reset (asynchronous, immediate):
  - flags = RESET_FLAGS.
  - All registered outputs = 0, including undef_seen.
  - Reset asserted mid-operation discards any in-flight strobe. No output pulses on the edge after deassertion unless in_valid is high.
- Accept: on a rising edge with in_valid=1 and stall=0.
- Condition evaluation is combinational on the stored flags, i.e. the flags before this instruction's update. Codes:
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C & ~Z
  - 9 LS: ~C | Z
  - 10 GE: N == V
  - 11 LT: N != V
  - 12 GT: ~Z & (N == V)
  - 13 LE: Z | (N != V)
  - 14 AL: 1
  - 15: 0, and sets undef_seen on accept.
- Flag update on accept, only when the condition passes:
  - flags[3:2] <= alu_flags[3:2] if flag_w[1].
  - flags[1:0] <= alu_flags[1:0] if flag_w[0].
  - A failed condition leaves flags unchanged.
- Registered outputs on accept:
  - cond_ex <= pass
  - pc_src <= pcs_in & pass
  - reg_write <= reg_w_in & ~no_write & pass
  - mem_write <= mem_w_in & pass
  - out_valid <= 1
- Latency: strobes appear 1 cycle after accept. flags reflects the update 1 cycle after accept.
- Back-to-back: instruction k+1 evaluates against flags already updated by instruction k. No bubble is needed.
- in_valid=0 and stall=0:
  - cond_ex, pc_src, reg_write, mem_write, out_valid <= 0.
  - flags hold.
- stall=1: all registers hold, including the strobes, regardless of in_valid.
- Strobes are single-cycle pulses unless stall holds them.
- undef_seen clears only on reset.

Test Plan:
- Reset with flags previously 4'b1111 -> flags=0000 and all strobes 0 immediately, before any clock edge.
- cond=14, flag_w=11, alu_flags=0100, reg_w_in=1 -> next cycle reg_write=1, cond_ex=1, flags=0100. Then cond=0 (EQ), mem_w_in=1 -> mem_write=1 next cycle.
- flags=0100, cond=1 (NE), flag_w=11, alu_flags=1000, pcs_in=1 -> cond_ex=0, pc_src=0, flags stay 0100.
- Partial write: flags=0000, flag_w=10, alu_flags=1111 -> flags=1100. Then cond=11 (LT, N=1, V=0) -> pass, cond_ex=1.
- no_write=1, reg_w_in=1, cond=14, flag_w=11, alu_flags=0110 -> reg_write=0, flags=0110. Then cond=8 (HI) -> fail; cond=9 (LS) -> pass.
- cond=15 with stall=1 -> no change. Drop stall -> undef_seen=1, cond_ex=0. undef_seen stays 1 through 5 further AL instructions until reset.
